// File: rtl/adc_spi_init_seq_pkg.sv
// ADC init sequencer shared definitions.
// State encoding, SPI word width and default ADC configuration words.
package adc_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  localparam int SPI_WORD_W = 24;

  // Software reset (0x000000) is issued elsewhere, not from this list.
  localparam logic [SPI_WORD_W-1:0] CFG_OUT_MODE = 24'h001401;
  localparam logic [SPI_WORD_W-1:0] CFG_CLKDIV   = 24'h000B00;
  localparam logic [SPI_WORD_W-1:0] CFG_XFER     = 24'h00FF01;

  function automatic logic [SPI_WORD_W-1:0] cfg_word(
    input logic [3:0] i
  );
    case (i)
      4'd0:    return CFG_OUT_MODE;
      4'd1:    return CFG_CLKDIV;
      4'd2:    return CFG_XFER;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/adc_spi_init_seq_if.sv
// Init FSM handshake and ADC SPI pins of the init sequencer.
// master = init FSM / bench side, slave = sequencer side.
interface adc_spi_init_seq_if;
  logic ADC_INIT;
  logic INIT_DONE;
  logic BUSY;
  logic ADC_CSB;
  logic ADC_SCLK;
  logic ADC_SDATA;

  modport master (
    output ADC_INIT,
    input  INIT_DONE, BUSY,
    input  ADC_CSB, ADC_SCLK, ADC_SDATA
  );

  modport slave (
    input  ADC_INIT,
    output INIT_DONE, BUSY,
    output ADC_CSB, ADC_SCLK, ADC_SDATA
  );
endinterface

// File: rtl/adc_spi_init_seq_rom.sv
// Registered configuration word ROM for the ADC init sequencer.
// Indices at or beyond NWORDS read back as zero.
module adc_init_rom
  import adc_init_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [3:0]            idx,
  output logic [SPI_WORD_W-1:0] word
);

  // One-cycle registered lookup
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      word <= '0;
    else if (int'(idx) < NWORDS)
      word <= cfg_word(idx);
    else
      word <= '0;
  end

endmodule

// File: rtl/adc_spi_init_seq.sv
// SPI register-write sequencer run while the init FSM is in Init.
// Sends NWORDS 24-bit words (SPI mode 0, MSB first), then pulses INIT_DONE.
module adc_spi_init_seq
  import adc_init_pkg::*;
#(
  parameter int NWORDS  = 4,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input logic               CLK,
  input logic               RST,
  adc_spi_init_seq_if.slave bus
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);
  localparam logic [3:0] IDX_LAST = 4'(NWORDS - 1);
  localparam logic [4:0] BIT_TOP  = 5'(SPI_WORD_W - 1);

  state_t                state, n_state;
  logic [3:0]            idx, n_idx;
  logic [4:0]            bitc, n_bitc;
  logic [3:0]            divc, n_divc;
  logic [7:0]            gapc, n_gapc;
  logic [SPI_WORD_W-1:0] sreg, n_sreg;
  logic [SPI_WORD_W-1:0] rom_q;
  logic                  csb, n_csb;
  logic                  sclk, n_sclk;
  logic                  done, busy;
  logic                  init;

  assign init = bus.ADC_INIT;

  // ROM is addressed with the next index so rom_q matches idx in Load
  adc_init_rom #(.NWORDS(NWORDS)) u_rom (
    .CLK  (CLK),
    .RST  (RST),
    .idx  (n_idx),
    .word (rom_q)
  );

  // State, counters and registered SPI/handshake outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      idx   <= '0;
      bitc  <= '0;
      divc  <= '0;
      gapc  <= '0;
      sreg  <= '0;
      csb   <= 1'b1;
      sclk  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= n_state;
      idx   <= n_idx;
      bitc  <= n_bitc;
      divc  <= n_divc;
      gapc  <= n_gapc;
      sreg  <= n_sreg;
      csb   <= n_csb;
      sclk  <= n_sclk;
      done  <= (n_state == ST_DONE);
      busy  <= (n_state inside {ST_LOAD, ST_SHIFT,
                                ST_GAP, ST_DONE});
    end
  end

  // Next-state logic; SDATA is sreg[23], so shifting
  // at each period end presents the next bit
  always_comb begin
    n_state = state;
    n_idx   = idx;
    n_bitc  = bitc;
    n_divc  = divc;
    n_gapc  = gapc;
    n_sreg  = sreg;
    n_csb   = csb;
    n_sclk  = sclk;
    case (state)
      ST_IDLE: begin
        if (init) n_state = ST_LOAD;
      end
      ST_LOAD: begin
        n_sreg  = rom_q;
        n_csb   = 1'b0;
        n_sclk  = 1'b0;
        n_divc  = '0;
        n_bitc  = BIT_TOP;
        n_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (divc != DIV_LAST) begin
          n_divc = divc + 4'd1;
        end else begin
          n_divc = '0;
          n_sclk = ~sclk;
          if (sclk) begin
            n_sreg = {sreg[SPI_WORD_W-2:0], 1'b0};
            n_bitc = bitc - 5'd1;
            if (bitc == '0) begin
              n_bitc  = '0;
              n_csb   = 1'b1;
              n_gapc  = '0;
              n_state = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (gapc != GAP_LAST) begin
          n_gapc = gapc + 8'd1;
        end else if (idx == IDX_LAST) begin
          n_state = ST_DONE;
        end else begin
          n_idx   = idx + 4'd1;
          n_state = ST_LOAD;
        end
      end
      ST_DONE: begin
        n_idx   = '0;
        n_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (!init) n_state = ST_IDLE;
      end
      default: n_state = ST_IDLE;
    endcase
    // Losing the request mid-sequence drops the SPI transaction
    if (!init && (state inside {ST_LOAD, ST_SHIFT, ST_GAP})) begin
      n_state = ST_IDLE;
      n_idx   = '0;
      n_bitc  = '0;
      n_divc  = '0;
      n_gapc  = '0;
      n_sreg  = '0;
      n_csb   = 1'b1;
      n_sclk  = 1'b0;
    end
  end

  assign bus.INIT_DONE = done;
  assign bus.BUSY      = busy;
  assign bus.ADC_CSB   = csb;
  assign bus.ADC_SCLK  = sclk;
  assign bus.ADC_SDATA = sreg[SPI_WORD_W-1];

endmodule

// File: tb/tb_adc_spi_init_seq.sv
// Directed bench for adc_spi_init_seq: default and reduced instances.
// SPI windows are decoded on SCLK rising edges and compared to constants.
module tb_adc_spi_init_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_spi_init_seq_if bus_a ();
  adc_spi_init_seq_if bus_b ();

  adc_spi_init_seq dut_a (
    .CLK (clk),
    .RST (rst),
    .bus (bus_a)
  );

  adc_spi_init_seq #(
    .NWORDS  (1),
    .CLK_DIV (2),
    .GAP_CYC (1)
  ) dut_b (
    .CLK (clk),
    .RST (rst),
    .bus (bus_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [23:0] exp_w [0:3];

  // Monitor input select: 0 = dut_a, 1 = dut_b
  logic sel = 1'b0;
  logic m_csb, m_sclk, m_sdata, m_done, m_busy;
  assign m_csb   = sel ? bus_b.ADC_CSB   : bus_a.ADC_CSB;
  assign m_sclk  = sel ? bus_b.ADC_SCLK  : bus_a.ADC_SCLK;
  assign m_sdata = sel ? bus_b.ADC_SDATA : bus_a.ADC_SDATA;
  assign m_done  = sel ? bus_b.INIT_DONE : bus_a.INIT_DONE;
  assign m_busy  = sel ? bus_b.BUSY      : bus_a.BUSY;

  int          len_q  [$];
  int          nb_q   [$];
  int          gap_q  [$];
  logic [23:0] word_q [$];

  int          cyc = 0;
  int          low_len = 0;
  int          hi_len = 0;
  int          nbits = 0;
  logic [23:0] sh = '0;
  logic        seen = 1'b0;
  logic        have_rise = 1'b0;
  int          last_rise = 0;
  int          per_min = 99;
  int          per_max = 0;
  int          run = 0;
  int          hi_min = 99;
  int          hi_max = 0;
  int          done_cnt = 0;
  time         t_done = 0;
  time         t_start = 0;
  logic        p_csb = 1'b1;
  logic        p_sclk = 1'b0;

  // Window / bit decoder, sampled on the falling clock edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!m_csb) low_len <= low_len + 1;
    else        hi_len  <= hi_len + 1;
    if (m_csb && !p_csb) begin
      len_q.push_back(low_len);
      nb_q.push_back(nbits);
      word_q.push_back(sh);
      hi_len <= 1;
    end
    if (!m_csb && p_csb) begin
      if (seen) gap_q.push_back(hi_len);
      seen      <= 1'b1;
      low_len   <= 1;
      nbits     <= 0;
      sh        <= '0;
      have_rise <= 1'b0;
    end
    if (!m_csb && m_sclk && !p_sclk) begin
      sh    <= {sh[22:0], m_sdata};
      nbits <= nbits + 1;
      if (have_rise) begin
        if (cyc - last_rise < per_min) per_min <= cyc - last_rise;
        if (cyc - last_rise > per_max) per_max <= cyc - last_rise;
      end
      last_rise <= cyc;
      have_rise <= 1'b1;
    end
    if (m_sclk) begin
      run <= run + 1;
    end else if (p_sclk) begin
      if (run < hi_min) hi_min <= run;
      if (run > hi_max) hi_max <= run;
      run <= 0;
    end
    if (m_done) begin
      if (done_cnt == 0) t_done <= $time;
      done_cnt <= done_cnt + 1;
    end
    p_csb  <= m_csb;
    p_sclk <= m_sclk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    len_q.delete();
    nb_q.delete();
    gap_q.delete();
    word_q.delete();
    low_len   = 0;
    hi_len    = 0;
    nbits     = 0;
    sh        = '0;
    seen      = 1'b0;
    have_rise = 1'b0;
    per_min   = 99;
    per_max   = 0;
    run       = 0;
    hi_min    = 99;
    hi_max    = 0;
    done_cnt  = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step(1);
      n++;
    end
    check("done_seen", done_cnt, 1);
  endtask

  // Latency in cycles from the edge that first samples ADC_INIT=1
  function automatic int latency();
    return int'((t_done - t_start + 5) / 10);
  endfunction

  task automatic check_windows(input int n, input int len,
                               input int gap);
    check("win_cnt", len_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < len_q.size()) begin
        check("win_len", len_q[i], len);
        check("win_bits", nb_q[i], 24);
        check("win_word", word_q[i], exp_w[i]);
      end
    end
    check("gap_cnt", gap_q.size(), n - 1);
    foreach (gap_q[i]) check("gap_len", gap_q[i], gap);
  endtask

  initial begin
    exp_w[0] = 24'h001401;
    exp_w[1] = 24'h000B00;
    exp_w[2] = 24'h00FF01;
    exp_w[3] = 24'h000000;
    bus_a.ADC_INIT = 1'b0;
    bus_b.ADC_INIT = 1'b0;
    rst = 1'b1;
    step(3);
    check("rst_done",  bus_a.INIT_DONE, 0);
    check("rst_busy",  bus_a.BUSY, 0);
    check("rst_csb",   bus_a.ADC_CSB, 1);
    check("rst_sclk",  bus_a.ADC_SCLK, 0);
    check("rst_sdata", bus_a.ADC_SDATA, 0);
    rst = 1'b0;
    step(3);

    // Nominal: 4 words, 4*(1+192+8)+1 = 805 cycles
    clear_mon();
    bus_a.ADC_INIT = 1'b1;
    t_start = $time;
    wait_done(1200);
    check("nom_lat", latency(), 805);
    check("nom_busy", m_busy, 1);
    // CSB-high run between words = 8 gap + 1 load cycle
    check_windows(4, 192, 9);
    check("nom_per_min", per_min, 8);
    check("nom_per_max", per_max, 8);
    check("nom_hi_min", hi_min, 4);
    check("nom_hi_max", hi_max, 4);

    // ADC_INIT stuck high: stays in Hold
    step(2000);
    check("stuck_wins", len_q.size(), 4);
    check("stuck_done", done_cnt, 1);
    check("stuck_csb", m_csb, 1);
    check("stuck_busy", m_busy, 0);

    // Release then idle: nothing restarts
    bus_a.ADC_INIT = 1'b0;
    step(50);
    check("idle_wins", len_q.size(), 4);
    check("idle_busy", m_busy, 0);

    // Re-assert, drop one cycle after INIT_DONE
    clear_mon();
    bus_a.ADC_INIT = 1'b1;
    t_start = $time;
    wait_done(1200);
    check("re_lat", latency(), 805);
    step(1);
    bus_a.ADC_INIT = 1'b0;
    step(400);
    check("hs_wins", len_q.size(), 4);
    check("hs_done", done_cnt, 1);
    check("hs_word0", word_q.size() > 0 ? word_q[0] : 24'hxxxxxx,
          24'h001401);
    check("hs_busy", m_busy, 0);

    // Abort during bit 10 of word 1 (14th rising SCLK)
    clear_mon();
    bus_a.ADC_INIT = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (len_q.size() == 1 && nbits == 14) break;
      step(1);
    end
    check("ab_reach", nbits, 14);
    check("ab_pre_csb", m_csb, 0);
    check("ab_pre_busy", m_busy, 1);
    bus_a.ADC_INIT = 1'b0;
    step(1);
    check("ab_csb", m_csb, 1);
    check("ab_sclk", m_sclk, 0);
    check("ab_busy", m_busy, 0);
    step(400);
    check("ab_nodone", done_cnt, 0);

    // Restart after abort: word 0 first
    clear_mon();
    bus_a.ADC_INIT = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (len_q.size() >= 1) break;
      step(1);
    end
    check("ab_re_word0", len_q.size() > 0 ? word_q[0] : 24'hxxxxxx,
          24'h001401);

    // Async reset mid-shift of word 2
    for (int n = 0; n < 1000; n++) begin
      if (len_q.size() == 2 && nbits == 5) break;
      step(1);
    end
    check("rs_reach", nbits, 5);
    check("rs_pre_csb", m_csb, 0);
    rst = 1'b1;
    #1;
    check("rs_csb",   bus_a.ADC_CSB, 1);
    check("rs_sclk",  bus_a.ADC_SCLK, 0);
    check("rs_sdata", bus_a.ADC_SDATA, 0);
    check("rs_busy",  bus_a.BUSY, 0);
    check("rs_done",  bus_a.INIT_DONE, 0);
    bus_a.ADC_INIT = 1'b0;
    step(1);
    rst = 1'b0;
    step(5);
    clear_mon();
    bus_a.ADC_INIT = 1'b1;
    t_start = $time;
    wait_done(1200);
    check("rs_lat", latency(), 805);
    check_windows(4, 192, 9);
    bus_a.ADC_INIT = 1'b0;
    step(5);

    // Reduced instance: 1 word, 1+96+1+1 = 99 cycles
    sel = 1'b1;
    step(2);
    clear_mon();
    bus_b.ADC_INIT = 1'b1;
    t_start = $time;
    wait_done(300);
    check("sw_lat", latency(), 99);
    check_windows(1, 96, 0);
    check("sw_per_min", per_min, 4);
    check("sw_per_max", per_max, 4);
    check("sw_hi_min", hi_min, 2);
    check("sw_hi_max", hi_max, 2);
    bus_b.ADC_INIT = 1'b0;
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
